// File: rtl/push_btn_array.sv
// rtl/push_btn_array.sv - N-channel synchronised, debounced push-button array with press flags and counters
// Optional registered irq output is enabled by defining PUSH_BTN_ARRAY_IRQ_EN.
module push_btn_array #(
    parameter int Channels     = 4,
    parameter int DebounceWait = 10,
    parameter int DebounceSize = 4,
    parameter int CountSize    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [11:0]          inst,
    input  logic                 inst_en,
    input  logic [Channels-1:0]  buttons,
    output logic                 button_status,
    output logic [CountSize-1:0] button_count,
`ifdef PUSH_BTN_ARRAY_IRQ_EN
    output logic                 irq,
`endif
    output logic                 error
);

    localparam logic [3:0] OP_RDBS = 4'h1;
    localparam logic [3:0] OP_RDCT = 4'h2;
    localparam logic [3:0] OP_CLR  = 4'h3;
    localparam logic [3:0] OP_MASK = 4'h4;

    localparam logic [DebounceSize-1:0] WAIT_LAST = DebounceSize'(DebounceWait - 1);
    localparam logic [CountSize-1:0]    COUNT_MAX = {CountSize{1'b1}};

    typedef enum logic {
        ST_READY,
        ST_ERROR
    } state_t;

    state_t state_q;

    logic [Channels-1:0]     sync1_q;
    logic [Channels-1:0]     sync2_q;
    logic [Channels-1:0]     stable_q;
    logic [Channels-1:0]     stable_d;
    logic [Channels-1:0]     press;
    logic [DebounceSize-1:0] db_cnt_q [Channels];
    logic [DebounceSize-1:0] db_cnt_d [Channels];
    logic [Channels-1:0]     pending_q;
    logic [Channels-1:0]     pending_d;
    logic [Channels-1:0]     mask_q;
    logic [Channels-1:0]     mask_d;
    logic [CountSize-1:0]    count_q [Channels];
    logic [CountSize-1:0]    count_d [Channels];

    logic [3:0]           opcode;
    logic [7:0]           imm;
    logic [Channels-1:0]  sel;
    logic [Channels-1:0]  clr_flag;
    logic [Channels-1:0]  clr_count;
    logic                 accept;
    logic                 imm_ok;
    logic                 bad_inst;
    logic                 do_rdbs;
    logic                 do_rdct;
    logic                 do_clr;
    logic                 do_mask;
    logic                 rd_status;
    logic [CountSize-1:0] rd_count;

    assign opcode    = inst[11:8];
    assign imm       = inst[7:0];
    assign accept    = inst_en && (state_q == ST_READY);
    assign imm_ok    = |sel;
    assign do_rdbs   = accept && (opcode == OP_RDBS) && imm_ok;
    assign do_rdct   = accept && (opcode == OP_RDCT) && imm_ok;
    assign do_clr    = accept && (opcode == OP_CLR);
    assign do_mask   = accept && (opcode == OP_MASK);
    assign bad_inst  = accept && ((opcode > OP_MASK) ||
                                  (((opcode == OP_RDBS) || (opcode == OP_RDCT)) && !imm_ok));
    assign rd_status = |(pending_q & sel);
    assign clr_flag  = do_clr ? '1 : (do_rdbs ? sel : '0);
    assign clr_count = do_clr ? '1 : (do_rdct ? sel : '0);
    assign mask_d    = do_mask ? imm[Channels-1:0] : mask_q;

    always_comb begin
        sel      = '0;
        rd_count = '0;
        for (int i = 0; i < Channels; i++) begin
            sel[i] = (imm == 8'(i));
            if (imm == 8'(i)) begin
                rd_count = count_q[i];
            end
        end
    end

    // Clears use the pre-edge values, so a press landing on the same edge survives the clear.
    always_comb begin
        for (int i = 0; i < Channels; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = '0;
            press[i]    = 1'b0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == WAIT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    press[i]    = sync2_q[i] & mask_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            if (clr_count[i]) begin
                count_d[i] = CountSize'(press[i]);
            end else if (press[i] && (count_q[i] != COUNT_MAX)) begin
                count_d[i] = count_q[i] + 1'b1;
            end else begin
                count_d[i] = count_q[i];
            end
        end
        pending_d = (pending_q & ~clr_flag) | press;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            for (int i = 0; i < Channels; i++) begin
                db_cnt_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            sync1_q   <= buttons;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            for (int i = 0; i < Channels; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    // Error is terminal: only reset returns to Ready, the channel datapath keeps running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_READY;
            error         <= 1'b0;
            button_status <= 1'b0;
            button_count  <= '0;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (bad_inst) begin
                        state_q <= ST_ERROR;
                        error   <= 1'b1;
                    end
                    if (do_rdbs) begin
                        button_status <= rd_status;
                    end
                    if (do_rdct) begin
                        button_count <= rd_count;
                    end
                end
                default: begin
                    state_q <= ST_ERROR;
                    error   <= 1'b1;
                end
            endcase
        end
    end

`ifdef PUSH_BTN_ARRAY_IRQ_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(pending_q & mask_q);
        end
    end
`endif

endmodule
